// File: rtl/counter_seq_ctrl_if.sv
// Config/control/status bundle for counter_seq_ctrl.
// The master side drives config and commands; the slave side is the sequencer.
interface counter_seq_ctrl_if #(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned PCNT_W = 4
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [WIDTH-1:0]  cfg_limit;
    logic [PCNT_W-1:0] cfg_periods;
    logic              start;
    logic              pause;
    logic              stop;
    logic [WIDTH-1:0]  count;
    logic [PCNT_W-1:0] period_cnt;
    logic              tick;
    logic              done;
    logic              busy;
    logic              err;

    modport master (
        output cfg_valid, cfg_limit, cfg_periods, start, pause, stop,
        input  cfg_ready, count, period_cnt, tick, done, busy, err
    );

    modport slave (
        input  cfg_valid, cfg_limit, cfg_periods, start, pause, stop,
        output cfg_ready, count, period_cnt, tick, done, busy, err
    );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Programmable interval sequencer: 12-bit up-counter wrapping at a configurable limit,
// with start/pause/stop control, per-period tick and a done pulse after the last period.
module counter_seq_ctrl #(
    parameter int unsigned       WIDTH         = 12,
    parameter int unsigned       PCNT_W        = 4,
    parameter logic [WIDTH-1:0]  DEFAULT_LIMIT = WIDTH'(15)
) (
    input  logic                 clk,
    input  logic                 reset,
    counter_seq_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic [WIDTH-1:0]  limit_q, limit_d;
    logic [PCNT_W-1:0] periods_q, periods_d;
    logic [PCNT_W-1:0] period_cnt_q, period_cnt_d;
    logic              tick_q, tick_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [WIDTH-1:0]  eff_limit;
    logic [PCNT_W-1:0] pcnt_inc;

    // A same-cycle config offer takes effect for a start in that cycle.
    assign eff_limit = bus.cfg_valid ? bus.cfg_limit : limit_q;
    assign pcnt_inc  = period_cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        limit_d      = limit_q;
        periods_d    = periods_q;
        period_cnt_d = period_cnt_q;
        tick_d       = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.cfg_valid) begin
                    limit_d   = bus.cfg_limit;
                    periods_d = bus.cfg_periods;
                end
                if (bus.start) begin
                    if (eff_limit != '0) begin
                        state_d      = StRun;
                        count_d      = '0;
                        period_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (bus.stop) begin
                    state_d      = StIdle;
                    count_d      = '0;
                    period_cnt_d = '0;
                end else if (bus.pause) begin
                    state_d = StPause;
                end else if (count_q != limit_q) begin
                    count_d = count_q + 1'b1;
                end else begin
                    count_d      = '0;
                    tick_d       = 1'b1;
                    period_cnt_d = pcnt_inc;
                    if (periods_q != '0 && pcnt_inc == periods_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
            end
            StPause: begin
                if (bus.stop) begin
                    state_d      = StIdle;
                    count_d      = '0;
                    period_cnt_d = '0;
                end else if (bus.start) begin
                    state_d = StRun;
                end
            end
            StDone: begin
                state_d = StIdle;
                count_d = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            count_q      <= '0;
            limit_q      <= DEFAULT_LIMIT;
            periods_q    <= '0;
            period_cnt_q <= '0;
            tick_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            limit_q      <= limit_d;
            periods_q    <= periods_d;
            period_cnt_q <= period_cnt_d;
            tick_q       <= tick_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.count      = count_q;
    assign bus.period_cnt = period_cnt_q;
    assign bus.tick       = tick_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.cfg_ready  = (state_q == StIdle);
    assign bus.busy       = (state_q == StRun) || (state_q == StPause);
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl: directed scenarios then random commands,
// checked every cycle against an arithmetic reference model.
module tb_counter_seq_ctrl;
    logic clk;
    logic reset;

    counter_seq_ctrl_if #(.WIDTH(12), .PCNT_W(4)) bus ();

    counter_seq_ctrl #(.WIDTH(12), .PCNT_W(4), .DEFAULT_LIMIT(12'd15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] count;
        logic [3:0]  pcnt;
        logic        tick;
        logic        done;
        logic        err;
        logic        ready;
        logic        busy;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   stim_done = 0;

    // Reference model: a run is "active" (running or paused) or not; a done cycle is
    // a one-cycle tail after the final period.
    int m_limit, m_periods, m_count, m_pcnt;
    bit m_active, m_paused, m_final;

    task automatic model(input bit r, input bit cv, input int cl, input int cp,
                         input bit st, input bit pa, input bit sp);
        obs_t e;
        int   lim;
        e = '0;
        if (r) begin
            m_limit = 15; m_periods = 0; m_count = 0; m_pcnt = 0;
            m_active = 0; m_paused = 0; m_final = 0;
        end else if (m_final) begin
            m_final = 0;
            m_count = 0;
        end else if (!m_active) begin
            lim = cv ? cl : m_limit;
            if (cv) begin
                m_limit   = cl;
                m_periods = cp;
            end
            if (st) begin
                if (lim == 0) begin
                    e.err = 1'b1;
                end else begin
                    m_active = 1; m_paused = 0; m_count = 0; m_pcnt = 0;
                end
            end
        end else if (sp) begin
            m_active = 0; m_paused = 0; m_count = 0; m_pcnt = 0;
        end else if (m_paused) begin
            if (st) m_paused = 0;
        end else if (pa) begin
            m_paused = 1;
        end else if (m_count == m_limit) begin
            m_count = 0;
            e.tick  = 1'b1;
            m_pcnt  = (m_pcnt + 1) % 16;
            if (m_periods != 0 && m_pcnt == m_periods) begin
                m_active = 0;
                m_final  = 1;
                e.done   = 1'b1;
            end
        end else begin
            m_count = m_count + 1;
        end
        e.count = 12'(m_count);
        e.pcnt  = 4'(m_pcnt);
        e.ready = !m_active && !m_final;
        e.busy  = m_active;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit r, input bit cv, input int cl, input int cp,
                        input bit st, input bit pa, input bit sp);
        @(negedge clk);
        reset           = r;
        bus.cfg_valid   = cv;
        bus.cfg_limit   = 12'(cl);
        bus.cfg_periods = 4'(cp);
        bus.start       = st;
        bus.pause       = pa;
        bus.stop        = sp;
        model(r, cv, cl, cp, st, pa, sp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are presented every cycle, so pop one expectation per edge.
    initial begin
        obs_t a, e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a.count = bus.count;
                a.pcnt  = bus.period_cnt;
                a.tick  = bus.tick;
                a.done  = bus.done;
                a.err   = bus.err;
                a.ready = bus.cfg_ready;
                a.busy  = bus.busy;
                n_checks++;
                if (a === e) n_pass++;
                else
                    $display("FAIL outputs cycle %0d: got count=%0d pcnt=%0d tick=%b done=%b err=%b ready=%b busy=%b, want count=%0d pcnt=%0d tick=%b done=%b err=%b ready=%b busy=%b",
                             cyc, a.count, a.pcnt, a.tick, a.done, a.err, a.ready, a.busy,
                             e.count, e.pcnt, e.tick, e.done, e.err, e.ready, e.busy);
            end
        end
    end

    initial begin
        int cl;
        reset = 1'b1;
        bus.cfg_valid = 0; bus.cfg_limit = '0; bus.cfg_periods = '0;
        bus.start = 0; bus.pause = 0; bus.stop = 0;

        // Default config, continuous mode.
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        idle(50);
        // L=3, P=2 finite run ending in done.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 3, 2, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        idle(12);
        // L=5 pause at count 2 for three cycles, then resume.
        step(0, 1, 5, 0, 1, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 1, 0);
        idle(2);
        step(0, 0, 0, 0, 1, 0, 0);
        idle(8);
        // Stop with pause at count==limit (L=3).
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 3, 0, 1, 0, 0);
        idle(3);
        step(0, 0, 0, 0, 0, 1, 1);
        idle(2);
        // Limit 0 rejected, then limit 2 accepted in the start cycle.
        step(0, 1, 0, 0, 1, 0, 0);
        idle(1);
        step(0, 1, 2, 0, 1, 0, 0);
        idle(7);
        // Reset mid-run after a config offer during RUN.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        idle(7);
        step(0, 1, 9, 0, 0, 0, 0);
        idle(3);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 1, 0, 0);
        idle(20);
        // PAUSE: stop beats start.
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0, 1);
        idle(2);

        for (int i = 0; i < 4000; i++) begin
            cl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40))
                                             : int'($urandom_range(0, 6));
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 4) == 0, cl, int'($urandom_range(0, 4)),
                 $urandom_range(0, 6) == 0,
                 $urandom_range(0, 14) == 0,
                 $urandom_range(0, 29) == 0);
        end
        idle(1);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        stim_done = 1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Programmable interval sequencer built around an internal 12-bit up-counter.
- Replaces the free-running up-counter wherever software or upstream logic must configure the wrap limit, start, pause, stop and count a fixed number of periods.
- Emits a one-cycle tick per period and a done pulse after the final period.
- Sits between the control/config path and any datapath consumer of `count`/`tick`.

Parameters:
- WIDTH, 12, counter and limit width.
- PCNT_W, 4, width of period-count config and status.
- DEFAULT_LIMIT, 12'd15, limit loaded on reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high; one clock, no other clock domain.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  high only in IDLE; config accepted when cfg_valid && cfg_ready at an edge.
- cfg_limit  in  WIDTH  wrap limit L; period = L+1 cycles.
- cfg_periods  in  PCNT_W  number of periods P; 0 = run continuously.
- start  in  1  start from IDLE, or resume from PAUSE.
- pause  in  1  freeze counting (RUN only).
- stop  in  1  abort to IDLE (RUN/PAUSE).
- count  out  WIDTH  current counter value.
- period_cnt  out  PCNT_W  periods completed in the current run.
- tick  out  1  one-cycle pulse on wrap.
- done  out  1  one-cycle pulse after the final period.
- busy  out  1  high in RUN and PAUSE.
- err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- States: IDLE, RUN, PAUSE, DONE. All outputs registered, except cfg_ready and busy, which decode state.
- Reset, synchronous at edge with reset=1:
  - state=IDLE, count=0, period_cnt=0, tick=0, done=0, err=0.
  - limit=DEFAULT_LIMIT, periods=0.
  - Reset overrides every other input, mid-run included.
- IDLE:
  - cfg_valid accepted: latch limit and periods. Any value is accepted, including limit 0.
  - start with effective limit != 0: go to RUN, count=0, period_cnt=0.
  - Effective limit/periods = the values presented on cfg_* when cfg_valid is high in the same cycle, otherwise the latched values.
  - start with effective limit == 0: err=1 for one cycle, stay IDLE.
  - pause and stop ignored.
- RUN, priority stop > pause > count:
  - stop: go to IDLE, count=0, period_cnt=0, no tick.
  - pause: go to PAUSE, count holds, no tick even if count==limit.
  - count<limit: count+1.
  - count==limit: count=0, tick=1, period_cnt+1.
  - If periods!=0 and period_cnt+1==periods: go to DONE with done=1 on the same edge as the tick.
  - In continuous mode period_cnt wraps modulo 2^PCNT_W.
  - start ignored.
- PAUSE:
  - Holds count and period_cnt.
  - stop goes to IDLE (cleared as above) and has priority over start.
  - start resumes RUN. Counting continues on the next edge; a held count==limit wraps on that edge.
  - pause ignored.
- DONE:
  - Lasts exactly one cycle with done=1, then IDLE.
  - count=0; period_cnt holds the final value until the next start.
  - start, stop and cfg are ignored; cfg_ready=0.
- tick, done and err are deasserted on every edge where they are not explicitly set.
- cfg_valid outside IDLE: not accepted, latched config unchanged.
- Latency:
  - start to first count=1: 1 cycle after RUN entry.
  - First tick asserts L+1 edges after the start edge.
- Arithmetic: all counters unsigned, no saturation; count never exceeds limit.

Test Plan:
- Reset then start, default config (L=15, P=0) -> count runs 0..15,0; tick high exactly when count returns to 0, every 16 cycles; period_cnt 1,2,3…; busy=1, done never.
- cfg_limit=3, cfg_periods=2 with cfg_valid, then start -> count 0,1,2,3,0,1,2,3,0. tick on the 4th and 8th edges; done=1 together with the 2nd tick. State IDLE the next cycle with cfg_ready=1 and period_cnt=2.
- L=5 running, pause asserted at count=2 for 3 cycles, then start -> count holds 2 during PAUSE with busy=1 and no tick; it resumes 3,4,5,0 with tick on the wrap.
- L=3 running, stop and pause asserted together on the edge where count==3 -> IDLE, count=0, period_cnt=0, no tick; cfg_ready=1 the next cycle.
- cfg_limit=0 with cfg_valid and start in the same IDLE cycle -> err pulse for 1 cycle, state stays IDLE. Then cfg_limit=2 with start in the same cycle -> RUN using limit 2, first tick after 3 edges.
- Reset asserted mid-run at count=7 (L=15); cfg_valid during RUN with cfg_limit=9 -> during RUN cfg_ready=0 and limit stays 15. Reset then clears count, period_cnt and all pulses, and restores limit=15 in IDLE.
